// File: rtl/factorial_arbiter.sv
// Round-robin arbiter sharing one factorial unit between two requesters.
// Optional WAIT-state watchdog enabled by defining FACT_ARB_TIMEOUT_EN.
module factorial_arbiter #(
  parameter int WIDTH       = 28,
  parameter int VALID_HOLD  = 1,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_n,
  output logic             req0_ready,
  output logic             rsp0_valid,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_n,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_ovf,
  output logic [WIDTH-1:0] fu_n,
  output logic             fu_valid_in,
  input  logic             fu_valid_out,
  input  logic             fu_ovrflow,
  input  logic [WIDTH-1:0] fu_d_out,
  output logic             busy,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] HOLD_LAST = 3'(VALID_HOLD - 1);

  state_t           state_reg, state_next;
  logic [2:0]       hold_cnt_reg, hold_cnt_next;
  logic             grant_reg, grant_next;
  logic             last_grant_reg, last_grant_next;
  logic [WIDTH-1:0] n_reg, n_next;
  logic [WIDTH-1:0] cap_data_reg, cap_data_next;
  logic             cap_ovf_reg, cap_ovf_next;
  logic             cap_vld_reg, cap_vld_next;
  logic [WIDTH-1:0] rsp_data_reg, rsp_data_next;
  logic             rsp_ovf_reg, rsp_ovf_next;

  logic       arb_sel;
  logic       state_idle;
  logic [1:0] req_valid_vec;
  logic [1:0] req_ready_vec;
  logic [1:0] rsp_valid_vec;

  assign req_valid_vec = {req1_valid, req0_valid};
  assign state_idle    = (state_reg == IDLE);

  // With both requesting, the one that was not served last wins.
  assign arb_sel = (req0_valid & req1_valid) ? ~last_grant_reg : req1_valid;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign req_ready_vec[gi] = rst & state_idle & req_valid_vec[gi] & (arb_sel == 1'(gi));
      assign rsp_valid_vec[gi] = (state_reg == RESP) & (grant_reg == 1'(gi));
    end
  endgenerate

  assign req0_ready  = req_ready_vec[0];
  assign req1_ready  = req_ready_vec[1];
  assign rsp0_valid  = rsp_valid_vec[0];
  assign rsp1_valid  = rsp_valid_vec[1];
  assign rsp_data    = rsp_data_reg;
  assign rsp_ovf     = rsp_ovf_reg;
  assign fu_n        = n_reg;
  assign fu_valid_in = (state_reg == ISSUE);
  assign busy        = ~state_idle;

`ifdef FACT_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic             tmo_flag_reg, tmo_flag_next;

  assign timeout = (state_reg == RESP) & tmo_flag_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_reg  <= '0;
      tmo_flag_reg <= 1'b0;
    end else begin
      tmo_cnt_reg  <= tmo_cnt_next;
      tmo_flag_reg <= tmo_flag_next;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      hold_cnt_reg   <= '0;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      n_reg          <= '0;
      cap_data_reg   <= '0;
      cap_ovf_reg    <= 1'b0;
      cap_vld_reg    <= 1'b0;
      rsp_data_reg   <= '0;
      rsp_ovf_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hold_cnt_reg   <= hold_cnt_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      n_reg          <= n_next;
      cap_data_reg   <= cap_data_next;
      cap_ovf_reg    <= cap_ovf_next;
      cap_vld_reg    <= cap_vld_next;
      rsp_data_reg   <= rsp_data_next;
      rsp_ovf_reg    <= rsp_ovf_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    hold_cnt_next   = hold_cnt_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    n_next          = n_reg;
    cap_data_next   = cap_data_reg;
    cap_ovf_next    = cap_ovf_reg;
    cap_vld_next    = cap_vld_reg;
    rsp_data_next   = rsp_data_reg;
    rsp_ovf_next    = rsp_ovf_reg;
`ifdef FACT_ARB_TIMEOUT_EN
    tmo_cnt_next    = tmo_cnt_reg;
    tmo_flag_next   = tmo_flag_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (req0_ready | req1_ready) begin
          grant_next    = arb_sel;
          n_next        = arb_sel ? req1_n : req0_n;
          hold_cnt_next = '0;
          cap_vld_next  = 1'b0;
          state_next    = ISSUE;
        end
      end

      ISSUE: begin
        // A unit that answers while the strobe is still held is remembered,
        // so the hold length is always honoured before responding.
        if (fu_valid_out & ~cap_vld_reg) begin
          cap_vld_next  = 1'b1;
          cap_data_next = fu_d_out;
          cap_ovf_next  = fu_ovrflow;
        end
        if (hold_cnt_reg == HOLD_LAST) begin
          if (cap_vld_reg | fu_valid_out) begin
            rsp_data_next = cap_vld_reg ? cap_data_reg : fu_d_out;
            rsp_ovf_next  = cap_vld_reg ? cap_ovf_reg : fu_ovrflow;
            state_next    = RESP;
          end else begin
            state_next    = WAIT;
`ifdef FACT_ARB_TIMEOUT_EN
            tmo_cnt_next  = '0;
`endif
          end
        end else begin
          hold_cnt_next = hold_cnt_reg + 3'd1;
        end
      end

      WAIT: begin
        if (fu_valid_out) begin
          rsp_data_next = fu_d_out;
          rsp_ovf_next  = fu_ovrflow;
          state_next    = RESP;
        end
`ifdef FACT_ARB_TIMEOUT_EN
        else if (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1)) begin
          rsp_data_next = '0;
          rsp_ovf_next  = 1'b1;
          tmo_flag_next = 1'b1;
          state_next    = RESP;
        end else begin
          tmo_cnt_next  = tmo_cnt_reg + 1'b1;
        end
`endif
      end

      RESP: begin
        last_grant_next = grant_reg;
        state_next      = IDLE;
`ifdef FACT_ARB_TIMEOUT_EN
        tmo_flag_next   = 1'b0;
`endif
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_factorial_arbiter.sv
// Self-checking bench for factorial_arbiter: stub factorial unit, cycle model, directed vectors.
module tb_factorial_arbiter;

  localparam int W   = 28;
  localparam int VH  = 1;
  localparam int TMO = 16;
  localparam longint FMAX = 134217727;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [W-1:0] req0_n = '0, req1_n = '0;
  logic         req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp_data, fu_n;
  logic         rsp_ovf, fu_valid_in, busy, timeout;
  logic         fu_valid_out = 1'b0, fu_ovrflow = 1'b0;
  logic [W-1:0] fu_d_out = '0;

  factorial_arbiter #(.WIDTH(W), .VALID_HOLD(VH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_n(req0_n), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .req1_valid(req1_valid), .req1_n(req1_n), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp_data(rsp_data), .rsp_ovf(rsp_ovf),
    .fu_n(fu_n), .fu_valid_in(fu_valid_in), .fu_valid_out(fu_valid_out),
    .fu_ovrflow(fu_ovrflow), .fu_d_out(fu_d_out),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // ---------------- stub factorial unit ----------------
  int  fu_lat     = 3;
  bit  fu_silent  = 0;
  bit  stale_req  = 0;
  bit  st_pend    = 0;
  bit  st_started = 0;
  int  st_cnt     = 0;
  logic [W-1:0] st_d;
  logic         st_o;

  function automatic void calc(input int n, output logic [W-1:0] d, output logic o);
    longint f = 1;
    o = 1'b0;
    for (int i = 2; i <= n; i++) begin
      if (!o) f = f * i;
      if (f > FMAX) o = 1'b1;
    end
    d = o ? {W{1'b1}} : W'(f);
  endfunction

  always @(posedge clk) begin
    #2;
    fu_valid_out = 1'b0;
    if (!rst) begin
      st_pend    = 0;
      st_started = 0;
    end else begin
      if (stale_req) begin
        fu_valid_out = 1'b1;
        fu_d_out     = 28'h00000AB;
        fu_ovrflow   = 1'b1;
      end
      if (st_pend) begin
        if (st_cnt == 0) begin
          fu_valid_out = 1'b1; fu_d_out = st_d; fu_ovrflow = st_o; st_pend = 0;
        end else st_cnt--;
      end
      if (fu_valid_in && !st_started) begin
        st_started = 1;
        calc(int'(fu_n), st_d, st_o);
        if (!fu_silent) begin
          if (fu_lat == 0) begin
            fu_valid_out = 1'b1; fu_d_out = st_d; fu_ovrflow = st_o;
          end else begin
            st_pend = 1; st_cnt = fu_lat - 1;
          end
        end
      end
      if (!fu_valid_in) st_started = 0;
    end
  end

  // ---------------- transaction-level model + per-cycle compare ----------------
  bit           m_job = 0, m_last = 1, m_grant = 0, m_rtmo = 0;
  int           m_acc = 0, m_fu = -1;
  logic [W-1:0] m_n = '0, m_data = '0, m_rdata = '0;
  logic         m_ovf = 1'b0, m_rovf = 1'b0;
  int           q_id[$];
  longint       q_data[$];
  bit           q_ovf[$];

  always @(negedge clk) begin
    bit e_r0, e_r1, e_busy, e_fvi, e_v0, e_v1, e_tmo, g, respond;
    logic [W-1:0] e_data;
    logic         e_ovf;
    int rc;
    if (rsp0_valid || rsp1_valid) begin
      q_id.push_back(rsp1_valid ? 1 : 0);
      q_data.push_back(longint'(rsp_data));
      q_ovf.push_back(rsp_ovf);
      $display("cycle %0d: rsp%0d data=%0d ovf=%0d timeout=%0d", cyc, rsp1_valid ? 1 : 0, rsp_data, rsp_ovf, timeout);
    end
    if (!rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_fu_valid_in", fu_valid_in, 0);
      chk("rst_rsp_valids", {rsp1_valid, rsp0_valid}, 0);
      chk("rst_ready", {req1_ready, req0_ready}, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_fu_n", fu_n, 0);
      m_job = 0; m_last = 1; m_data = '0; m_ovf = 1'b0; m_fu = -1;
    end else begin
      e_r0 = 0; e_r1 = 0; e_busy = 0; e_fvi = 0; e_v0 = 0; e_v1 = 0; e_tmo = 0;
      e_data = m_data; e_ovf = m_ovf; respond = 0; g = 0;
      if (!m_job) begin
        if (req0_valid || req1_valid) begin
          g = (req0_valid && req1_valid) ? !m_last : req1_valid;
          e_r0 = !g; e_r1 = g;
        end
      end else begin
        e_busy = 1;
        e_fvi  = (cyc <= m_acc + VH);
        if (m_fu >= 0) begin
          rc = ((m_acc + VH > m_fu) ? m_acc + VH : m_fu) + 1;
          if (cyc == rc) begin
            respond = 1;
            e_v0 = !m_grant; e_v1 = m_grant;
            e_data = m_rdata; e_ovf = m_rovf; e_tmo = m_rtmo;
          end
        end
        chk("fu_n", fu_n, m_n);
      end
      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);
      chk("busy", busy, e_busy);
      chk("fu_valid_in", fu_valid_in, e_fvi);
      chk("rsp0_valid", rsp0_valid, e_v0);
      chk("rsp1_valid", rsp1_valid, e_v1);
      chk("rsp_data", rsp_data, e_data);
      chk("rsp_ovf", rsp_ovf, e_ovf);
      chk("timeout", timeout, e_tmo);
      if (!m_job && (e_r0 || e_r1)) begin
        m_job = 1; m_acc = cyc; m_grant = g; m_fu = -1; m_rtmo = 0;
        m_n = g ? req1_n : req0_n;
      end else if (m_job && respond) begin
        m_job = 0; m_last = m_grant; m_data = m_rdata; m_ovf = m_rovf;
      end else if (m_job && m_fu < 0 && cyc > m_acc) begin
        if (fu_valid_out) begin
          m_fu = cyc; m_rdata = fu_d_out; m_rovf = fu_ovrflow;
        end
`ifdef FACT_ARB_TIMEOUT_EN
        else if (cyc == m_acc + VH + TMO) begin
          m_fu = cyc; m_rdata = '0; m_rovf = 1'b1; m_rtmo = 1;
        end
`endif
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clear_q();
    q_id.delete(); q_data.delete(); q_ovf.delete();
  endtask

  task automatic do_req(input bit v0, input bit v1, input int n0, input int n1);
    bit p0 = v0, p1 = v1;
    int budget = 0;
    @(posedge clk); #1;
    req0_valid = v0; req0_n = W'(n0);
    req1_valid = v1; req1_n = W'(n1);
    while ((p0 || p1 || busy) && budget < 300) begin
      @(negedge clk);
      if (p0 && req0_ready) p0 = 0;
      if (p1 && req1_ready) p1 = 0;
      @(posedge clk); #1;
      if (!p0) req0_valid = 1'b0;
      if (!p1) req1_valid = 1'b0;
      budget++;
    end
    chk("req_cycle_budget", budget < 300, 1);
  endtask

  task automatic expect_rsp(input string name, input int idx, input int id, input longint data, input bit ovf);
    chk({name, "_count"}, q_id.size() > idx, 1);
    if (q_id.size() > idx) begin
      chk({name, "_id"}, id, q_id[idx]);
      chk({name, "_data"}, q_data[idx], data);
      chk({name, "_ovf"}, q_ovf[idx], ovf);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    int sz;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("post_reset_busy", busy, 0);

    fu_lat = 3;
    clear_q(); do_req(1, 0, 5, 0); expect_rsp("req0_n5", 0, 0, 120, 0);
    chk("req0_n5_single", q_id.size(), 1);
    clear_q(); do_req(0, 1, 0, 8); expect_rsp("req1_n8", 0, 1, 40320, 0);
    clear_q(); do_req(0, 1, 0, 0); expect_rsp("req1_n0", 0, 1, 1, 0);

    apply_reset();
    clear_q();
    do_req(1, 1, 4, 5);
    do_req(1, 1, 4, 5);
    expect_rsp("both_a", 0, 0, 24, 0);
    expect_rsp("both_b", 1, 1, 120, 0);
    expect_rsp("both_c", 2, 0, 24, 0);
    expect_rsp("both_d", 3, 1, 120, 0);

    clear_q(); do_req(1, 0, 45, 0); expect_rsp("req0_n45", 0, 0, 28'hFFFFFFF, 1);
    clear_q(); fu_lat = 1; do_req(0, 1, 0, 11); expect_rsp("req1_n11", 0, 1, 39916800, 0);
    clear_q(); do_req(1, 0, 12, 0); expect_rsp("req0_n12", 0, 0, 28'hFFFFFFF, 1);
    clear_q(); fu_lat = 0; do_req(1, 0, 3, 0); expect_rsp("issue_path_n3", 0, 0, 6, 0);

    // stale unit pulse while idle must be ignored
    clear_q();
    @(posedge clk); #1 stale_req = 1;
    @(posedge clk); #1 stale_req = 0;
    repeat (3) @(posedge clk);
    #1 chk("stale_busy", busy, 0);
    chk("stale_no_rsp", q_id.size(), 0);

    // reset while waiting on a silent unit
    fu_silent = 1; fu_lat = 2;
    @(posedge clk); #1 req0_valid = 1'b1; req0_n = W'(7);
    @(posedge clk); #1 req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk("wait_busy_before_rst", busy, 1);
    #1 rst = 1'b0;
    #1 chk("async_busy", busy, 0);
    chk("async_fu_valid_in", fu_valid_in, 0);
    chk("async_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; fu_silent = 0;
    sz = q_id.size();
    repeat (10) @(posedge clk);
    chk("no_rsp_after_rst", q_id.size(), sz);
    clear_q(); do_req(0, 1, 0, 6); expect_rsp("after_rst_n6", 0, 1, 720, 0);

`ifdef FACT_ARB_TIMEOUT_EN
    clear_q(); fu_silent = 1; do_req(1, 0, 2, 0); fu_silent = 0;
    expect_rsp("timeout_rsp", 0, 0, 0, 1);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
